// File: rtl/rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// rom_read_arbiter
//
// Purpose:
//   Shares one synchronous single-port sprite/background ROM among NUM_REQ
//   pixel-pipeline requesters (wall tiler, fireboy, icegirl, door/diamond
//   sprites). A round-robin arbiter produces a combinational one-hot grant.
//   The winning address is registered into the ROM. A one-hot tag travels
//   alongside the read, so rd_valid tells which requester owns rom_data.
//
// Build option:
//   ARB_BG_PRIORITY_EN - when defined, requester 0 (background) always wins
//                        while it requests. Requesters 1..NUM_REQ-1 share
//                        round-robin only while req[0] is low.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset     in   synchronous active-high reset
//   req       in   per-requester read request, held until granted
//   req_addr  in   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   grant     out  one-hot (or zero) combinational grant
//   rom_addr  out  registered ROM address
//   rom_data  in   ROM read data
//   rd_valid  out  registered one-hot tag, valid ROM_LAT+1 clocks after accept
//   rd_data   out  rom_data pass-through
//   busy      out  a read is in the issue stage or the latency pipeline
// -----------------------------------------------------------------------------
module rom_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

`ifdef ARB_BG_PRIORITY_EN
    // Requester 0 bypasses the rotation, so the pointer only covers 1..N-1.
    localparam logic [PTR_W-1:0] RST_PTR = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] RST_PTR = PTR_W'(0);
`endif

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_win_idx;
    logic               w_win_v;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [NUM_REQ-1:0] w_grant;
    int                 w_start;
    int                 w_cand;

    logic [ADDR_W-1:0]  r_rom_addr;
    logic               r_issue_v;
    logic [PTR_W-1:0]   r_issue_id;
    logic [NUM_REQ-1:0] r_pipe_tag [ROM_LAT];
    logic [NUM_REQ-1:0] r_rd_valid;
    logic               w_pipe_busy;

    // Decode a requester index into its one-hot tag.
    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PTR_W-1:0] id);
        logic [NUM_REQ-1:0] v_tag;
        v_tag     = '0;
        v_tag[id] = 1'b1;
        return v_tag;
    endfunction

    // Winner search: first requesting index at or after the rotating pointer.
    always_comb begin
        w_win_v   = 1'b0;
        w_win_idx = '0;
        w_start   = 0;
        w_cand    = 0;
`ifdef ARB_BG_PRIORITY_EN
        if (req[0]) begin
            w_win_v   = 1'b1;
            w_win_idx = '0;
        end else begin
            // A zero pointer can only be a corrupted state; restart at 1.
            if (r_rr_ptr == '0) begin
                w_start = 1;
            end else begin
                w_start = int'(r_rr_ptr);
            end
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                w_cand = w_start + k;
                // Wrap N-1 -> 1, skipping requester 0.
                if (w_cand >= NUM_REQ) begin
                    w_cand = w_cand - (NUM_REQ - 1);
                end else begin
                    w_cand = w_cand;
                end
                if (!w_win_v && req[PTR_W'(w_cand)]) begin
                    w_win_v   = 1'b1;
                    w_win_idx = PTR_W'(w_cand);
                end else begin
                    w_win_v   = w_win_v;
                end
            end
        end
`else
        w_start = int'(r_rr_ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = w_start + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end else begin
                w_cand = w_cand;
            end
            if (!w_win_v && req[PTR_W'(w_cand)]) begin
                w_win_v   = 1'b1;
                w_win_idx = PTR_W'(w_cand);
            end else begin
                w_win_v   = w_win_v;
            end
        end
`endif
    end

    // Grant vector, winning address mux and pointer advance for the accept edge.
    always_comb begin
        w_grant    = '0;
        w_win_addr = '0;
        w_ptr_nxt  = r_rr_ptr;
        if (w_win_v) begin
            w_grant[w_win_idx] = 1'b1;
            w_win_addr         = req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
        end else begin
            w_grant    = '0;
        end
`ifdef ARB_BG_PRIORITY_EN
        // Background grants leave the rotation among the sprites untouched.
        if (w_win_idx == '0) begin
            w_ptr_nxt = r_rr_ptr;
        end else if (w_win_idx == PTR_W'(NUM_REQ - 1)) begin
            w_ptr_nxt = PTR_W'(1);
        end else begin
            w_ptr_nxt = w_win_idx + PTR_W'(1);
        end
`else
        if (w_win_idx == PTR_W'(NUM_REQ - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_win_idx + PTR_W'(1);
        end
`endif
    end

    assign w_accept = |(req & w_grant);

    // Issue stage, latency tag pipeline and rd_valid register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rr_ptr   <= RST_PTR;
            r_rom_addr <= '0;
            r_issue_v  <= 1'b0;
            r_issue_id <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                r_pipe_tag[s] <= '0;
            end
            r_rd_valid <= '0;
        end else begin
            if (w_accept) begin
                r_rom_addr <= w_win_addr;
                r_issue_v  <= 1'b1;
                r_issue_id <= w_win_idx;
                r_rr_ptr   <= w_ptr_nxt;
            end else begin
                r_issue_v  <= 1'b0;
            end
            r_pipe_tag[0] <= r_issue_v ? f_onehot(r_issue_id) : '0;
            for (int s = 1; s < ROM_LAT; s++) begin
                r_pipe_tag[s] <= r_pipe_tag[s-1];
            end
            r_rd_valid <= r_pipe_tag[ROM_LAT-1];
        end
    end

    // Any tag still travelling through the latency pipeline.
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int s = 0; s < ROM_LAT; s++) begin
            w_pipe_busy = w_pipe_busy | (|r_pipe_tag[s]);
        end
    end

    assign grant    = w_grant;
    assign rom_addr = r_rom_addr;
    assign rd_valid = r_rd_valid;
    assign rd_data  = rom_data;
    assign busy     = r_issue_v | w_pipe_busy;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter (NUM_REQ=4, ADDR_W=19, DATA_W=8, ROM_LAT=1).
module tb_rom_read_arbiter;

    logic        Clk;
    logic        Reset;
    logic [3:0]  req;
    logic [18:0] addr [4];
    logic [75:0] req_addr;
    logic [3:0]  grant;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  rd_valid;
    logic [7:0]  rd_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

    rom_read_arbiter #(
        .NUM_REQ(4),
        .ADDR_W (19),
        .DATA_W (8),
        .ROM_LAT(1)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (req),
        .req_addr(req_addr),
        .grant   (grant),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .busy    (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] e;
        Reset    = 1'b1;
        req      = 4'b1111;
        rom_data = 8'h00;
        for (int i = 0; i < 4; i++) addr[i] = 19'h00100 + 19'(i);

        // 1: reset with every requester asking
        tick();
        tick();
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_grant", 32'(grant), 32'h1);
        Reset = 1'b0;
        req   = 4'b0000;
        #1;
        chk("idle_grant", 32'(grant), 32'h0);

        // 2: single read from requester 2
        req     = 4'b0100;
        addr[2] = 19'h00C00;
        #1;
        chk("t2_grant", 32'(grant), 32'h4);
        tick();
        req = 4'b0000;
        chk("t2_rom_addr", 32'(rom_addr), 32'h00C00);
        chk("t2_busy_issue", 32'(busy), 32'h1);
        chk("t2_rdv_e0", 32'(rd_valid), 32'h0);
        tick();
        chk("t2_rdv_e1", 32'(rd_valid), 32'h0);
        chk("t2_busy_pipe", 32'(busy), 32'h1);
        tick();
        chk("t2_rdv_e2", 32'(rd_valid), 32'h4);
        chk("t2_busy_done", 32'(busy), 32'h0);
        rom_data = 8'h5A;
        #1;
        chk("t2_rd_data", 32'(rd_data), 32'h5A);
        tick();
        chk("t2_rdv_clear", 32'(rd_valid), 32'h0);
        addr[2] = 19'h00102;

        Reset = 1'b1;
        tick();
        Reset = 1'b0;

`ifndef ARB_BG_PRIORITY_EN
        // 3: all four requesting for 8 clocks
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            e = 4'b0001 << (k % 4);
            chk("t3_grant", 32'(grant), 32'(e));
            tick();
            chk("t3_rom_addr", 32'(rom_addr), 32'(addr[k % 4]));
            e = (k >= 2) ? (4'b0001 << ((k - 2) % 4)) : 4'b0000;
            chk("t3_rd_valid", 32'(rd_valid), 32'(e));
        end
        req = 4'b0000;
        tick();
        chk("t3_tail_rdv2", 32'(rd_valid), 32'h4);
        tick();
        chk("t3_tail_rdv3", 32'(rd_valid), 32'h8);
        tick();
        chk("t3_tail_idle", 32'(rd_valid), 32'h0);
        chk("t3_tail_busy", 32'(busy), 32'h0);

        // 4: move pointer to 2, then requesters 1 and 3 alternate
        req = 4'b0010;
        #1;
        chk("t4_setup_grant", 32'(grant), 32'h2);
        tick();
        req = 4'b1010;
        for (int k = 0; k < 20; k++) begin
            #1;
            e = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            chk("t4_grant", 32'(grant), 32'(e));
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
`else
        // 6: background priority, then sprites alternate
        req = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t6_bg_grant", 32'(grant), 32'h1);
            tick();
            chk("t6_bg_addr", 32'(rom_addr), 32'(addr[0]));
        end
        req = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            #1;
            e = (k % 2 == 0) ? 4'b0010 : 4'b0100;
            chk("t6_rr_grant", 32'(grant), 32'(e));
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
`endif

        // 5: reset one clock after an accept discards the read
        req = 4'b0001;
        #1;
        chk("t5_grant", 32'(grant), 32'h1);
        tick();
        req   = 4'b0000;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t5_rdv_after_rst", 32'(rd_valid), 32'h0);
        chk("t5_busy_after_rst", 32'(busy), 32'h0);
        rom_data = 8'hA5;
        tick();
        chk("t5_rdv_slot", 32'(rd_valid), 32'h0);
        tick();
        chk("t5_rdv_late", 32'(rd_valid), 32'h0);

        // Reset together with a request: reset wins
        req = 4'b0100;
        #1;
        tick();
        req = 4'b0000;
        chk("t5_pre_addr", 32'(rom_addr), 32'(addr[2]));
        Reset = 1'b1;
        req   = 4'b0010;
        tick();
        chk("t5_sim_addr", 32'(rom_addr), 32'h0);
        chk("t5_sim_busy", 32'(busy), 32'h0);
        Reset = 1'b0;
        req   = 4'b1111;
        #1;
        chk("t5_sim_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        chk("t5_sim_rdv", 32'(rd_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
